// File: rtl/alu_issue_unit.sv
// Issue/writeback controller for the complex-arithmetic alu: reads operands from a
// 4-entry register file, captures the alu result, saturates it and writes it back.
`timescale 1ns/1ps
module alu_issue_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] instr,
  input  logic [7:0] imm,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [1:0] alu_cmd,
  input  logic [7:0] alu_res_im,
  input  logic [7:0] alu_res_re,
  output logic       done,
  output logic       ovf,
  input  logic [1:0] dbg_sel,
  output logic [7:0] dbg_data
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_WB = 2'd2} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_rd;
  logic       r_ldi;
  logic [7:0] r_imm;
  logic [7:0] r_res_im;
  logic [7:0] r_res_re;
  logic [7:0] r_regs [4];

  logic       w_accept;
  logic [1:0] w_op;
  logic       w_clip_im;
  logic       w_clip_re;
  logic [3:0] w_sat_im;
  logic [3:0] w_sat_re;
  logic [7:0] w_wdata;

  // Returns {clipped, saturated 4-bit value} for a signed 8-bit input.
  function automatic logic [4:0] sat4(input logic [7:0] v);
    if ($signed(v) > 8'sd7)
      return {1'b1, 4'b0111};
    else if ($signed(v) < -8'sd8)
      return {1'b1, 4'b1000};
    else
      return {1'b0, v[3:0]};
  endfunction

  assign w_op     = instr[7:6];
  assign w_accept = instr_valid && instr_ready;
  assign {w_clip_im, w_sat_im} = sat4(r_res_im);
  assign {w_clip_re, w_sat_re} = sat4(r_res_re);
  assign w_wdata  = r_ldi ? r_imm : {w_sat_im, w_sat_re};
  assign dbg_data = r_regs[dbg_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = !w_accept ? S_IDLE : ((w_op == 2'b11) ? S_WB : S_EXEC);
      S_EXEC:  w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    done        = 1'b0;
    ovf         = 1'b0;
    case (r_state)
      S_IDLE: instr_ready = 1'b1;
      S_WB: begin
        done = 1'b1;
        ovf  = !r_ldi && (w_clip_im || w_clip_re);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) r_regs[i] <= '0;
      r_rd     <= '0;
      r_ldi    <= 1'b0;
      r_imm    <= '0;
      r_res_im <= '0;
      r_res_re <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_cmd  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_rd    <= instr[5:4];
          r_ldi   <= (w_op == 2'b11);
          r_imm   <= imm;
          alu_a   <= r_regs[instr[3:2]];
          alu_b   <= r_regs[instr[1:0]];
          alu_cmd <= {w_op == 2'b10, w_op == 2'b01};
        end
        S_EXEC: begin
          r_res_im <= alu_res_im;
          r_res_re <= alu_res_re;
        end
        S_WB:    r_regs[r_rd] <= w_wdata;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Issue/writeback controller sitting directly upstream of the complex-arithmetic `alu`, and consuming its output. It accepts one instruction at a time over a valid/ready handshake and holds a 4-entry register file of packed complex values (`{im[3:0], re[3:0]}`, both signed 4-bit). For each instruction it drives `alu` operands and command from registers, captures `result_im`/`result_re` (signed 8-bit), saturates them to 4 bits and writes the destination register.

## Interface
- No parameters. Widths are fixed by the `alu` operand format.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  unit can accept an instruction (high only in IDLE).
- `instr`  in  8  `[7:6]` op (00 ADD, 01 SUB, 10 MUL, 11 LDI), `[5:4]` rd, `[3:2]` rs1, `[1:0]` rs2.
- `imm`  in  8  packed complex immediate for LDI, sampled with the instruction.
- `alu_a`  out  8  operand A to `alu.a` (registered).
- `alu_b`  out  8  operand B to `alu.b` (registered).
- `alu_cmd`  out  2  to `alu.cmd`: 00 add, 01 sub, 10 mul (registered).
- `alu_res_im`  in  8  from `alu.result_im`, signed.
- `alu_res_re`  in  8  from `alu.result_re`, signed.
- `done`  out  1  one-cycle pulse when the destination register is written.
- `ovf`  out  1  valid with `done`: at least one part was saturated.
- `dbg_sel`  in  2  debug read address.
- `dbg_data`  out  8  combinational read of `regs[dbg_sel]`.

## Operation
- **Register file:** `regs[0..3]`, 8 bits each, packed as `{im, re}`.
- **States:**
  - IDLE: `instr_ready`=1. On `instr_valid & instr_ready`:
    - latch `rd`, op and `imm`;
    - `alu_a <= regs[rs1]`, `alu_b <= regs[rs2]`, `alu_cmd <= {op==MUL, op==SUB}`.
    - Next state is EXEC for ADD/SUB/MUL, WB for LDI.
  - EXEC: `alu_a`/`alu_b`/`alu_cmd` are stable. Capture `alu_res_im`/`alu_res_re` into result registers. Next state is WB.
  - WB:
    - write `regs[rd]`: the saturated result, or `imm` unchanged for LDI;
    - assert `done` for this cycle, and `ovf` if saturation occurred (LDI: 0);
    - next state is IDLE.
- **Saturation (per part, signed 8 → 4):**
  - value > 7 → 7 (4'b0111);
  - value < −8 → −8 (4'b1000);
  - otherwise the low 4 bits.
- ADD/SUB overflow wraps inside `alu` (4-bit result, sign-extended). It is never saturated here and never flags `ovf`.
- Operands are read at issue. rd may equal rs1 and/or rs2: the old value is used and the new value is written in WB.
- `alu_a`, `alu_b` and `alu_cmd` hold their last values outside EXEC. `alu` is combinational, so results are valid in the same cycle.
- LDI leaves `alu_a`, `alu_b` and `alu_cmd` loaded but does not use them.
- An unrecognised state returns to IDLE.

## Timing
- **Reset (async, while `rst_n`=0):**
  - state is IDLE, all `regs` = 0;
  - `alu_a`=0, `alu_b`=0, `alu_cmd`=0;
  - `done`=0, `ovf`=0, `instr_ready`=1.
- **ALU op:** handshake at edge N → EXEC for cycle N+1 → WB for cycle N+2 (`done`=1; register updated at edge N+3) → `instr_ready`=1 again in cycle N+3. Throughput is one ALU instruction per 3 cycles.
- **LDI:** handshake at edge N → WB for cycle N+1 → `instr_ready`=1 in cycle N+2. Throughput is one LDI per 2 cycles.
- **Back-pressure:** `instr_valid` while `instr_ready`=0 is ignored. The source holds `instr`/`imm` until the handshake.
- `dbg_data` reflects a WB write from the edge that ends WB onward.
- **Reset mid-instruction:** the instruction is aborted, no writeback, `done` is not asserted, and all state is cleared immediately.
- `done` and `ovf` are never high outside WB.

## Test plan
- **Reset:** assert `rst_n`=0 mid-EXEC → outputs immediately at reset values. After release, `dbg_data`=0x00 for all `dbg_sel`, and `instr_ready`=1.
- **LDI:**
  - LDI r1, imm=0x23 → `done` two cycles after the handshake, `ovf`=0, `regs[1]`=0x23;
  - LDI r2, imm=0x1F;
  - LDI r3, 0x7F → `regs[3]`=0x7F.
- **ADD/SUB:** with r1=0x23, r2=0x1F:
  - ADD r3,r1,r2 → `alu_cmd`=00 in EXEC, `regs[3]`=0x32;
  - SUB r0,r1,r2 → `alu_cmd`=01, `regs[0]`=0x14.
  - In both cases `done` comes 3 cycles after the handshake and `ovf`=0.
- **MUL saturation:** r1=0x33, MUL r2,r1,r1 → `alu` gives im=18, re=0 → `regs[2]`=0x70, `ovf`=1.
  - r1=0x2E, r2=0x22, MUL r3,r1,r2 (re (−2+2i)(2+2i) = −8) → re=0x8, im=0, no clip → `regs[3]`=0x08, `ovf`=0.
- **Handshake/aliasing:**
  - hold `instr_valid`=1 continuously over back-to-back instructions → exactly one accept per 3 cycles;
  - ADD r1,r1,r1 with r1=0x11 → `regs[1]`=0x22.
